// File: rtl/barrelshifter_arbiter_pkg.sv
// Shared types and helpers for the barrelshifter arbiter slice.
// Operation codes for the shared shifter and a one-hot to index encoder.
package bsh_pkg;

    typedef enum logic [2:0] {
        OP_LSR     = 3'b000,
        OP_ASR     = 3'b001,
        OP_ROR     = 3'b010,
        OP_ROR_ALT = 3'b011,
        OP_LSL     = 3'b100,
        OP_ASL     = 3'b101,
        OP_ROL     = 3'b110,
        OP_ROL_ALT = 3'b111
    } bsh_op_e;

    // OR-reduction encoder; the result is only meaningful for one-hot or zero input.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/barrelshifter_arbiter_if.sv
// Request/response bundle between the issue lanes and the shared shifter arbiter.
// slave = arbiter side, master = requester/consumer side.
interface barrelshifter_arbiter_if #(
    parameter int D_SIZE = 8,
    parameter int N_REQ  = 4
);
    localparam int SW  = $clog2(D_SIZE);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid_in;
    logic [N_REQ-1:0]        req_ready_out;
    logic [N_REQ*D_SIZE-1:0] req_x_in;
    logic [N_REQ*SW-1:0]     req_s_in;
    logic [N_REQ*3-1:0]      req_op_in;
    logic                    rsp_valid_out;
    logic                    rsp_ready_in;
    logic [D_SIZE-1:0]       rsp_y_out;
    logic                    rsp_zf_out;
    logic                    rsp_vf_out;
    logic [IDW-1:0]          rsp_id_out;

    modport slave (
        input  req_valid_in, req_x_in, req_s_in, req_op_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_y_out, rsp_zf_out, rsp_vf_out, rsp_id_out
    );

    modport master (
        output req_valid_in, req_x_in, req_s_in, req_op_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_y_out, rsp_zf_out, rsp_vf_out, rsp_id_out
    );

endinterface

// File: rtl/barrelshifter.sv
// Combinational barrel shifter: logical/arithmetic shifts and rotates.
// ASL keeps the sign bit and flags overflow when significant bits are lost.
module barrelshifter
    import bsh_pkg::*;
#(
    parameter  int D_SIZE = 8,
    localparam int SW     = $clog2(D_SIZE)
) (
    input  logic [D_SIZE-1:0] x,
    input  logic [SW-1:0]     s,
    input  bsh_op_e           op,
    output logic [D_SIZE-1:0] y,
    output logic              zf,
    output logic              vf
);

    logic [2*D_SIZE-1:0] rot_r;
    logic [2*D_SIZE-1:0] rot_l;
    logic [D_SIZE-1:0]   shl;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y     = '0;
        vf    = 1'b0;
        rot_r = {x, x} >> s;
        rot_l = {x, x} << s;
        shl   = x << s;
        case (op)
            OP_LSR:             y = x >> s;
            OP_ASR:             y = $signed(x) >>> s;
            OP_ROR, OP_ROR_ALT: y = rot_r[D_SIZE-1:0];
            OP_LSL:             y = shl;
            OP_ASL: begin
                y  = {x[D_SIZE-1], shl[D_SIZE-2:0]};
                vf = ($signed(shl) >>> s) != $signed(x);
            end
            OP_ROL, OP_ROL_ALT: y = rot_l[2*D_SIZE-1:D_SIZE];
        endcase
        zf = (y == '0);
    end

endmodule

// File: rtl/barrelshifter_arbiter_rr.sv
// Round-robin arbiter: masked/unmasked lowest-set priority encoder plus a
// pointer that advances past the last winner.
module rr_arbiter
    import bsh_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic [N-1:0]  masked;
    logic [N-1:0]  pick;

    always_comb begin
        masked = '0;
        for (int k = 0; k < N; k++) begin
            masked[k] = req[k] && (IW'(k) >= ptr);
        end
        // Requests at or above the pointer win; otherwise wrap to the lowest index.
        if (|masked) pick = masked & (~masked + N'(1));
        else         pick = req & (~req + N'(1));
    end

    assign gnt = en ? pick : '0;
    assign idx = IW'(onehot_to_idx(32'(pick)));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr <= '0;
        end else if (en && (|req)) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/barrelshifter_arbiter.sv
// Shares one barrelshifter among N_REQ requesters with a one-entry response register.
// Optional BSHARB_STICKY_VF_EN adds a sticky overflow flag with vf_clr_in / vf_sticky_out.
module barrelshifter_arbiter
    import bsh_pkg::*;
#(
    parameter int D_SIZE = 8,
    parameter int N_REQ  = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
`ifdef BSHARB_STICKY_VF_EN
    input  logic vf_clr_in,
    output logic vf_sticky_out,
`endif
    barrelshifter_arbiter_if.slave bus
);

    localparam int SW  = $clog2(D_SIZE);
    localparam int IDW = $clog2(N_REQ);

    logic              slot_free;
    logic              load;
    logic [N_REQ-1:0]  gnt;
    logic [IDW-1:0]    gnt_idx;
    logic [D_SIZE-1:0] x_sel;
    logic [SW-1:0]     s_sel;
    bsh_op_e           op_sel;
    logic [D_SIZE-1:0] sh_y;
    logic              sh_zf;
    logic              sh_vf;

    logic              rsp_valid;
    logic [D_SIZE-1:0] rsp_y;
    logic              rsp_zf;
    logic              rsp_vf;
    logic [IDW-1:0]    rsp_id;

    // Reset gates the enable so nothing is granted while rst_n_in is low.
    assign slot_free = !rsp_valid || bus.rsp_ready_in;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .req      (bus.req_valid_in),
        .en       (slot_free && rst_n_in),
        .gnt      (gnt),
        .idx      (gnt_idx)
    );

    assign bus.req_ready_out = gnt;
    assign load              = |gnt;

    assign x_sel  = bus.req_x_in[gnt_idx*D_SIZE +: D_SIZE];
    assign s_sel  = bus.req_s_in[gnt_idx*SW +: SW];
    assign op_sel = bsh_op_e'(bus.req_op_in[gnt_idx*3 +: 3]);

    barrelshifter #(.D_SIZE(D_SIZE)) u_bsh (
        .x  (x_sel),
        .s  (s_sel),
        .op (op_sel),
        .y  (sh_y),
        .zf (sh_zf),
        .vf (sh_vf)
    );

    // NOTE: the response payload is reset along with valid so a post-reset bus shows all zeros.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_zf    <= 1'b0;
            rsp_vf    <= 1'b0;
            rsp_id    <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_y     <= sh_y;
            rsp_zf    <= sh_zf;
            rsp_vf    <= sh_vf;
            rsp_id    <= gnt_idx;
        end else if (bus.rsp_ready_in) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid_out = rsp_valid;
    assign bus.rsp_y_out     = rsp_y;
    assign bus.rsp_zf_out    = rsp_zf;
    assign bus.rsp_vf_out    = rsp_vf;
    assign bus.rsp_id_out    = rsp_id;

`ifdef BSHARB_STICKY_VF_EN
    // A new overflow wins over a same-cycle clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)             vf_sticky_out <= 1'b0;
        else if (load && sh_vf)    vf_sticky_out <= 1'b1;
        else if (vf_clr_in)        vf_sticky_out <= 1'b0;
    end
`endif

endmodule

// File: doc/barrelshifter_arbiter.md
Name: barrelshifter_arbiter

Overview:
- Shares one `barrelshifter` instance between N_REQ requesters. Each requester sends an operation as x, s and op.
- A round-robin arbiter grants one request per cycle. The selected operands drive the shared combinational barrelshifter, and the result is captured in a single-entry output register.
- The output register returns y, zf, vf and the requester id over one valid/ready response channel.
- Sits between the per-lane issue logic and the shared shift datapath.

Parameters:
- D_SIZE, 8, data width passed to `barrelshifter`; power of two, ≥ 4.
- N_REQ, 4, number of requesters; ≥ 2.
- SW, $clog2(D_SIZE), shift-amount width (localparam).
- IDW, $clog2(N_REQ), requester-id width (localparam).

Ports:
- clk_in  input  1  sole clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  N_REQ  bit k = requester k has a pending operation.
- req_ready_out  output  N_REQ  one-hot or zero; bit k = requester k accepted this cycle.
- req_x_in  input  N_REQ*D_SIZE  operand for requester k at [k*D_SIZE +: D_SIZE].
- req_s_in  input  N_REQ*SW  shift amount for requester k at [k*SW +: SW].
- req_op_in  input  N_REQ*3  opcode for requester k at [k*3 +: 3].
- rsp_valid_out  output  1  response register holds a result.
- rsp_ready_in  input  1  consumer accepts the response.
- rsp_y_out  output  D_SIZE  shifted result.
- rsp_zf_out  output  1  zero flag of the result.
- rsp_vf_out  output  1  overflow flag; only meaningful for ASL.
- rsp_id_out  output  IDW  index of the requester that issued the result.

Behaviour:
- Reset: asynchronous, active-low. Clears rsp_valid_out and rsp_y/zf/vf/id to 0, and sets the priority pointer to 0. req_ready_out is 0 while rst_n_in is low.
- Slot free: `slot_free = !rsp_valid_out || rsp_ready_in`.
- Grant:
  - Computed only when slot_free.
  - The winner is the first k with req_valid_in[k], searching from the pointer upward modulo N_REQ.
  - req_ready_out = onehot(winner) when slot_free and any request is valid; otherwise 0.
  - A transfer occurs when req_valid_in[k] && req_ready_out[k].
- Pointer update: after a grant to k, the pointer becomes (k+1) mod N_REQ. It is unchanged when there is no grant.
- Latency: an operation accepted at edge t appears with rsp_valid_out = 1 after edge t. That is one cycle, and back-to-back throughput is one operation per cycle when rsp_ready_in is held high.
- Response hold: while rsp_valid_out && !rsp_ready_in, all rsp_* outputs stay stable and no grant is made.
- Drain without new grant: when rsp_ready_in && rsp_valid_out && no request is valid, rsp_valid_out falls to 0 on the next edge.
- Simultaneous drain and accept: the register is overwritten in the same edge and rsp_valid_out stays 1.
- Requester rule: a requester holds its payload stable from valid-high until ready. The arbiter does not depend on this for correctness.
- Opcodes are passed unmodified:
  - 000 LSR, 001 ASR, 01x ROR, 100 LSL, 101 ASL, 11x ROL.
  - All 8 codes are legal.
  - vf is nonzero only for 101.
- Combinational paths:
  - rsp_valid_out, rsp_* → req_ready_out (via slot_free).
  - req_valid_in → req_ready_out.
  - There is no combinational path from req_* payload to rsp_*.
- Reset asserted mid-response: the pending result is discarded and no response is emitted for it.

Optional Feature:
- Macro: BSHARB_STICKY_VF_EN.
- When defined, adds two ports:
  - vf_clr_in  input  1.
  - vf_sticky_out  output  1.
- vf_sticky_out is set on any edge that loads a result with vf = 1. It is cleared by vf_clr_in, and set takes priority when both occur in the same cycle. It resets to 0.
- When not defined, neither port nor the register exists.

Decomposition:
- Package bsh_pkg holds:
  - typedef enum logic [2:0] bsh_op_e: OP_LSR=000, OP_ASR=001, OP_ROR=010, OP_ROR_ALT=011, OP_LSL=100, OP_ASL=101, OP_ROL=110, OP_ROL_ALT=111.
  - A helper function onehot_to_idx.
- Sub-module rr_arbiter #(N) contains the pointer register plus the masked/unmasked priority encoder. Inputs: req vector and enable (slot_free). Outputs: onehot grant and index. It uses the same clk_in/rst_n_in.
- The top level performs the operand mux, instantiates barrelshifter, and holds the response register.

Test Plan (D_SIZE=8, N_REQ=4):
- Reset: hold rst_n_in low with all req_valid high → req_ready_out = 0000 and rsp_valid_out = 0. Release → first grant goes to requester 0.
- ASR: requester 2 alone, x=0x81, s=1, op=001 → next cycle rsp_y=0xC0, id=2, zf=0, vf=0.
- ASL overflow: requester 1, x=0x40, s=1, op=101 → rsp_y=0x00, zf=1, vf=1. With BSHARB_STICKY_VF_EN, vf_sticky_out = 1 until vf_clr_in.
- Round-robin: all four requesters valid continuously, rsp_ready_in = 1 → ids 0,1,2,3,0 on consecutive cycles. ROL x=0x81, s=1, op=110 on requester 3 → 0x03.
- Backpressure: hold rsp_ready_in = 0 for 3 cycles with a response pending → rsp_* stable and req_ready_out = 0000. Raise rsp_ready_in → a new grant occurs in the same cycle and rsp_valid_out stays 1.
- Reset mid-op: assert rst_n_in low while rsp_valid_out = 1 → rsp_valid_out drops immediately (asynchronously), and after release the pointer restarts at 0.
